data_bus_bridge: RTL and testbench
==================================

# data_bus_bridge

Data-side bus bridge sitting directly downstream of the single-cycle CPU's data port (dAddr/dataOut/DRAMwe/dataIn). It passes ordinary accesses through to the data RAM. It decodes a small MMIO window holding three registers: a buffered 8N1 UART transmitter, a status register, and a 32-bit cycle counter. Reads are combinational, so the single-cycle core sees results in the same cycle. Writes take effect on the rising clock edge.

## Interface
- CLKS_PER_BIT, 16, UART bit period in clk cycles (≥2)
- FIFO_DEPTH, 8, TX FIFO entries (power of 2, ≥2)
- MMIO_BASE, 32'hFFFF_0000, base of MMIO window; window = addresses whose [31:16] equal MMIO_BASE[31:16]

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- dAddr  in  32  CPU data address
- dataOut  in  32  CPU store data
- DRAMwe  in  1  CPU store strobe
- dataIn  out  32  load data returned to CPU (combinational)
- dram_addr  out  32  = dAddr always
- dram_wdata  out  32  = dataOut always
- dram_we  out  1  DRAMwe & ~mmio_hit
- dram_rdata  in  32  RAM read data
- uart_tx  out  1  serial output, idle high

## Operation
- Decode: mmio_hit = (dAddr[31:16] == MMIO_BASE[31:16]). Register select uses dAddr[3:2]; dAddr[1:0] is ignored.
- Non-MMIO access: dataIn = dram_rdata; dram_we follows DRAMwe.
- MMIO access: dram_we = 0. dataIn comes from the register map below.
- Offset 0x0, TXDATA: a write pushes dataOut[7:0] into the FIFO. If the FIFO is full, evaluated before any same-cycle pop, the byte is dropped and sticky OVF is set. Reads return 0.
- Offset 0x4, STATUS: reads return {28'b0, OVF, busy, full, empty}. A write with dataOut[3]=1 clears OVF. Other bits are read-only.
- Offset 0x8, CYCLE: reads return the counter value. A write loads dataOut; the write overrides the increment on that edge.
- Offset 0xC: reads return 0; writes are ignored.
- Cycle counter: +1 every cycle and wraps from 0xFFFF_FFFF to 0.
- TX FSM states: IDLE, START, DATA, STOP. A bit counter (0..CLKS_PER_BIT-1) and a bit index (0..7) drive the transitions.
  - IDLE: uart_tx=1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA with index 0.
  - DATA: uart_tx=shift[0], LSB first, CLKS_PER_BIT cycles per bit. After bit 7, go to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles. On the last cycle: if the FIFO is non-empty, pop and go to START (back-to-back frames); otherwise go to IDLE.
- busy = (state != IDLE).
- Simultaneous push and pop on a non-full FIFO: both occur and the count is unchanged. Push on an empty FIFO with no pop: count becomes 1.

## Timing
- Reset values:
  - state=IDLE, uart_tx=1, FIFO empty (pointers 0), OVF=0, CYCLE=0, busy=0.
  - dataIn/dram_* stay combinational and are unaffected by reset.
- Reset asserted mid-frame: uart_tx=1 on the next cycle, the FIFO is flushed, and the in-flight byte is lost.
- Write latency: a store at edge N is visible to a read in cycle N+1.
- Idle to start bit: TXDATA written at edge N, FIFO pops at edge N+1, uart_tx=0 from cycle N+1 onward.
- Frame length: exactly 10*CLKS_PER_BIT cycles, start edge to end of stop bit.
- Consecutive queued bytes: no idle gap; the next start bit immediately follows the stop bit.
- CYCLE read in the cycle after a write of V at edge N returns V. The read at N+2 returns V+1.

## Test plan
- Reset check: assert reset 2 cycles, then release.
  - uart_tx=1, STATUS read = 0x1, CYCLE read = 0 in the first cycle after reset.
- Pass-through:
  - Store 0xDEADBEEF to 0x0000_0040: dram_we=1, dram_addr=0x40, dram_wdata=0xDEADBEEF.
  - A load from 0x40 with dram_rdata=0x1234 gives dataIn=0x1234.
  - Store to 0xFFFF_0008 gives dram_we=0.
- Single byte, CLKS_PER_BIT=4: write 0xA5 to 0xFFFF_0000.
  - Sampling uart_tx mid-bit gives 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop) over 40 cycles.
  - STATUS busy=1 during the frame and returns to 0x1 after.
- FIFO full/overflow, FIFO_DEPTH=8: with the FSM held in reset-free idle, write 10 bytes back-to-back.
  - The first byte is popped immediately, so 9 bytes fit and the 10th is dropped: OVF=1.
  - The line carries 9 back-to-back frames with no idle gaps.
  - Writing 0x8 to STATUS clears OVF.
- CYCLE: write 0xFFFF_FFFE to 0xFFFF_0008. Reads on the following cycles return 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
- Reset mid-frame: queue 3 bytes, assert reset during DATA bit 3.
  - uart_tx=1 the next cycle, STATUS=0x1.
  - No further frames are transmitted.

Source files
------------

// File: rtl/data_bus_bridge.sv
// CPU data-port bridge: RAM pass-through plus an MMIO window (buffered 8N1 UART TX, status, cycle counter).
// Reads are combinational and writes land on the next edge; TX bytes written while the FIFO is full are dropped and flag OVF.

module bridge_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat,
  output logic             empty,
  output logic             full
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             in_ok;
  logic             out_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign out_dat = mem[rd_ptr_q];

  // Fullness is judged on the pre-edge count, so a push into a full FIFO is
  // refused even when a pop happens on the same edge.
  always_comb begin
    in_ok    = in_vld && !full;
    out_ok   = out_rdy && !empty;
    wr_ptr_d = wr_ptr_q + AW'(in_ok);
    rd_ptr_d = rd_ptr_q + AW'(out_ok);
    count_d  = count_q + CW'(in_ok) - CW'(out_ok);
  end

  always_ff @(posedge clk) begin
    if (in_ok) begin
      mem[wr_ptr_q] <= in_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

module data_bus_bridge #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] MMIO_BASE    = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dAddr,
  input  logic [31:0] dataOut,
  input  logic        DRAMwe,
  output logic [31:0] dataIn,
  output logic [31:0] dram_addr,
  output logic [31:0] dram_wdata,
  output logic        dram_we,
  input  logic [31:0] dram_rdata,
  output logic        uart_tx
);
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CYCLE  = 2'd2;

  logic             mmio_hit;
  logic [1:0]       reg_sel;
  logic             wr_txdata;
  logic             wr_status;
  logic             wr_cycle;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      cycle_q, cycle_d;

  logic             bit_last;
  logic             tx_pop;
  logic             busy;
  logic [7:0]       fifo_dat;
  logic             fifo_empty;
  logic             fifo_full;
  logic [31:0]      status_word;
  logic             unused_addr_bits;

  assign mmio_hit   = (dAddr[31:16] == MMIO_BASE[31:16]);
  assign reg_sel    = dAddr[3:2];
  assign wr_txdata  = mmio_hit && DRAMwe && (reg_sel == REG_TXDATA);
  assign wr_status  = mmio_hit && DRAMwe && (reg_sel == REG_STATUS);
  assign wr_cycle   = mmio_hit && DRAMwe && (reg_sel == REG_CYCLE);

  assign dram_addr  = dAddr;
  assign dram_wdata = dataOut;
  assign dram_we    = DRAMwe && !mmio_hit;

  assign unused_addr_bits = ^{dAddr[15:4], dAddr[1:0]};

  bridge_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (wr_txdata),
    .in_dat  (dataOut[7:0]),
    .out_rdy (tx_pop),
    .out_dat (fifo_dat),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign busy        = (state_q != ST_IDLE);
  assign status_word = {28'b0, ovf_q, busy, fifo_full, fifo_empty};

  always_comb begin
    dataIn = dram_rdata;
    if (mmio_hit) begin
      case (reg_sel)
        REG_STATUS: dataIn = status_word;
        REG_CYCLE:  dataIn = cycle_q;
        default:    dataIn = 32'h0;
      endcase
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (wr_txdata && fifo_full) begin
      ovf_d = 1'b1;
    end
    if (wr_status && dataOut[3]) begin
      ovf_d = 1'b0;
    end
    cycle_d = wr_cycle ? dataOut : cycle_q + 32'd1;
  end

  assign bit_last = (bit_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  // STOP reloads straight into START when another byte is queued, so
  // consecutive frames leave no idle cycle on the line.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_pop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        if (!fifo_empty) begin
          tx_pop  = 1'b1;
          shift_d = fifo_dat;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          if (!fifo_empty) begin
            tx_pop  = 1'b1;
            shift_d = fifo_dat;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    case (state_q)
      ST_START: uart_tx = 1'b0;
      ST_DATA:  uart_tx = shift_q[0];
      default:  uart_tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      ovf_q     <= 1'b0;
      cycle_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      ovf_q     <= ovf_d;
      cycle_q   <= cycle_d;
    end
  end
endmodule

// File: tb/tb_data_bus_bridge.sv
// Bench for data_bus_bridge: frame-schedule model checked every cycle plus directed literal checks.
module tb_data_bus_bridge;
  localparam int C     = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * C;

  localparam logic [31:0] A_TX  = 32'hFFFF_0000;
  localparam logic [31:0] A_ST  = 32'hFFFF_0004;
  localparam logic [31:0] A_CYC = 32'hFFFF_0008;
  localparam logic [31:0] A_RAM = 32'h0000_0100;

  logic        clk;
  logic        reset;
  logic [31:0] dAddr;
  logic [31:0] dataOut;
  logic        DRAMwe;
  logic [31:0] dataIn;
  logic [31:0] dram_addr;
  logic [31:0] dram_wdata;
  logic        dram_we;
  logic [31:0] dram_rdata;
  logic        uart_tx;

  data_bus_bridge #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (DEPTH),
    .MMIO_BASE    (32'hFFFF_0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .dAddr      (dAddr),
    .dataOut    (dataOut),
    .DRAMwe     (DRAMwe),
    .dataIn     (dataIn),
    .dram_addr  (dram_addr),
    .dram_wdata (dram_wdata),
    .dram_we    (dram_we),
    .dram_rdata (dram_rdata),
    .uart_tx    (uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
    end
  endtask

  // Model: every accepted byte becomes a frame with a fixed start edge.
  int          edge_n   = 0;
  bit          model_ok = 1'b0;
  int          f_start[$];
  int          f_acc[$];
  logic [7:0]  f_byte[$];
  logic        m_ovf;
  logic [31:0] m_cycle;

  function automatic int occ_at(input int t);
    int n = 0;
    foreach (f_start[i]) if (f_acc[i] <= t && f_start[i] > t) n++;
    return n;
  endfunction

  function automatic logic exp_tx(input int t);
    logic [7:0] b;
    int slot;
    foreach (f_start[i]) begin
      if (t >= f_start[i] && t < f_start[i] + FRAME) begin
        slot = (t - f_start[i]) / C;
        b = f_byte[i];
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return b[slot-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_status(input int t);
    logic busy_m = 1'b0;
    int occ;
    foreach (f_start[i]) if (t >= f_start[i] && t < f_start[i] + FRAME) busy_m = 1'b1;
    occ = occ_at(t);
    return {28'b0, m_ovf, busy_m, (occ == DEPTH), (occ == 0)};
  endfunction

  function automatic logic [31:0] exp_datain();
    if (dAddr[31:16] != 16'hFFFF) return dram_rdata;
    case (dAddr[3:2])
      2'd1:    return exp_status(edge_n);
      2'd2:    return m_cycle;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    int start;
    int prev_end;
    logic wr_any;
    edge_n++;
    if (reset) begin
      f_start.delete();
      f_acc.delete();
      f_byte.delete();
      m_ovf    = 1'b0;
      m_cycle  = 32'h0;
      model_ok = 1'b1;
    end else begin
      wr_any = DRAMwe && (dAddr[31:16] == 16'hFFFF);
      if (wr_any && dAddr[3:2] == 2'd0) begin
        if (occ_at(edge_n - 1) >= DEPTH) begin
          m_ovf = 1'b1;
        end else begin
          prev_end = (f_start.size() > 0) ? f_start[f_start.size()-1] + FRAME : 0;
          start = (prev_end > edge_n + 1) ? prev_end : edge_n + 1;
          f_start.push_back(start);
          f_acc.push_back(edge_n);
          f_byte.push_back(dataOut[7:0]);
        end
      end
      if (wr_any && dAddr[3:2] == 2'd1 && dataOut[3]) m_ovf = 1'b0;
      if (wr_any && dAddr[3:2] == 2'd2) m_cycle = dataOut;
      else m_cycle = m_cycle + 32'd1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      check("uart_tx", 32'(uart_tx), 32'(exp_tx(edge_n)));
      check("dataIn", dataIn, exp_datain());
      check("dram_we", 32'(dram_we), 32'(DRAMwe && (dAddr[31:16] != 16'hFFFF)));
      check("dram_addr", dram_addr, dAddr);
      check("dram_wdata", dram_wdata, dataOut);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    dAddr   = A_RAM;
    dataOut = 32'h0;
    DRAMwe  = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    dAddr   = addr;
    dataOut = data;
    DRAMwe  = 1'b1;
    tick();
    idle_bus();
  endtask

  task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp_v);
    dAddr  = addr;
    DRAMwe = 1'b0;
    #1;
    check(name, dataIn, exp_v);
  endtask

  logic exp_bits [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  int   busy_cnt;
  int   saw_low;

  initial begin
    reset      = 1'b1;
    dram_rdata = 32'h0;
    idle_bus();
    repeat (2) tick();
    reset = 1'b0;
    check("reset_uart_tx", 32'(uart_tx), 32'h1);
    rd_check("reset_status", A_ST, 32'h1);
    rd_check("reset_cycle", A_CYC, 32'h0);
    idle_bus();
    tick();

    // Pass-through and MMIO store blocking
    dAddr   = 32'h0000_0040;
    dataOut = 32'hDEAD_BEEF;
    DRAMwe  = 1'b1;
    #1;
    check("pt_we", 32'(dram_we), 32'h1);
    check("pt_addr", dram_addr, 32'h0000_0040);
    check("pt_wdata", dram_wdata, 32'hDEAD_BEEF);
    DRAMwe     = 1'b0;
    dram_rdata = 32'h0000_1234;
    #1;
    check("pt_load", dataIn, 32'h0000_1234);
    dAddr  = A_CYC;
    DRAMwe = 1'b1;
    #1;
    check("mmio_we_blocked", 32'(dram_we), 32'h0);
    idle_bus();
    tick();

    // Single byte 0xA5, sampled mid-bit
    wr(A_TX, 32'h0000_00A5);
    repeat (3) tick();
    for (int k = 0; k < 10; k++) begin
      dAddr = A_ST;
      #1;
      check($sformatf("a5_bit%0d", k), 32'(uart_tx), 32'(exp_bits[k]));
      check($sformatf("a5_status%0d", k), dataIn, 32'h5);
      if (k < 9) repeat (C) tick();
    end
    repeat (2) tick();
    rd_check("a5_status_after", A_ST, 32'h1);
    idle_bus();
    tick();

    // Overflow: ten back-to-back writes, nine frames
    for (int i = 0; i < 10; i++) wr(A_TX, 32'h10 + 32'(i));
    rd_check("ovf_status", A_ST, 32'hE);
    wr(A_ST, 32'h8);
    rd_check("ovf_cleared", A_ST, 32'h6);
    busy_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      dAddr = A_ST;
      #1;
      if (dataIn[2]) busy_cnt++;
      tick();
    end
    check("busy_cycles", 32'(busy_cnt), 32'd351);
    idle_bus();

    // Cycle counter wrap
    wr(A_CYC, 32'hFFFF_FFFE);
    rd_check("cyc_0", A_CYC, 32'hFFFF_FFFE);
    tick();
    rd_check("cyc_1", A_CYC, 32'hFFFF_FFFF);
    tick();
    rd_check("cyc_2", A_CYC, 32'h0000_0000);
    idle_bus();
    tick();

    // Reset during data bit 3 of the first of three queued frames
    wr(A_TX, 32'h0000_0033);
    wr(A_TX, 32'h0000_0044);
    wr(A_TX, 32'h0000_0055);
    repeat (16) tick();
    reset = 1'b1;
    tick();
    check("rst_mid_uart_tx", 32'(uart_tx), 32'h1);
    rd_check("rst_mid_status", A_ST, 32'h1);
    reset = 1'b0;
    idle_bus();
    saw_low = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (uart_tx !== 1'b1) saw_low++;
    end
    check("no_tx_after_reset", 32'(saw_low), 32'h0);
    rd_check("rst_final_status", A_ST, 32'h1);
    idle_bus();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
